life_engine: RTL
================

Name: life_engine

Overview:
- Parametrised, sequential Conway's Game of Life engine for a ROWS x COLS grid.
- It holds the grid in a register, accepts a grid load through a valid/ready handshake, then runs a requested number of generations at one generation per clock.
- It reports generation count, extinction and completion.
- It supersedes the fixed 8x8 combinational evolver as the top-level compute block; boundary mode is selectable between dead-edge and toroidal wrap.

Parameters:
- ROWS, 8, number of grid rows (>=3)
- COLS, 8, number of grid columns (>=3)
- GEN_W, 16, width of the generation request and generation counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous reset, active-low (asserted when 0)
- load_valid  in  1  load_grid is valid
- load_ready  out  1  engine can accept a load
- load_grid  in  ROWS*COLS  grid to load; cell (r,c) is bit r*COLS+c
- start  in  1  begin run; sampled only in IDLE
- num_gens  in  GEN_W  generations to compute; sampled with start
- wrap  in  1  1 = toroidal edges, 0 = out-of-grid cells are dead; sampled with start
- abort  in  1  terminate a run early
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a run completes normally
- grid_out  out  ROWS*COLS  current grid register
- gen_count  out  GEN_W  generations computed in the current or last run
- extinct  out  1  grid_out is all zero
- stable  out  1  last computed generation equalled its predecessor

Behaviour:
- Reset state: reset==0 at a clock edge forces the following, regardless of state, including mid-run:
  - state=IDLE, grid_out=0, gen_count=0, done=0, busy=0, stable=0.
  - extinct=1, because it is combinational from grid_out.
- States are IDLE, RUN and DONE.
- IDLE:
  - load_ready=1.
  - load_valid&load_ready: grid_out<=load_grid, stable<=0.
  - start (without load_valid): latch num_gens, latch wrap, gen_count<=0.
    - num_gens==0: go to DONE.
    - otherwise: go to RUN.
  - load_valid and start in the same cycle: load wins and start is ignored.
- RUN:
  - load_ready=0 and busy=1; load_valid is ignored.
  - Each cycle: grid_out<=next generation, gen_count<=gen_count+1, stable<=(next==grid_out).
  - When gen_count+1==latched num_gens, go to DONE.
  - abort: go to IDLE with no done and no grid update that cycle; gen_count holds.
  - abort has priority over completion.
- DONE:
  - done=1 for exactly one cycle; load_ready=0; then go to IDLE.
  - abort in DONE has no effect.
- Latency: with start sampled at edge E0, the generations are written at edges E1..EN, done is high in the cycle after EN, and IDLE is re-entered at EN+1.
- Next-generation rule:
  - Count the 8 neighbours of each cell.
  - Alive next iff count==3, or count==2 and the cell is currently alive.
  - The counter is at least 4 bits wide.
- Neighbour indexing:
  - wrap=0: neighbours outside 0..ROWS-1 / 0..COLS-1 contribute 0.
  - wrap=1: indices wrap modulo ROWS/COLS.
- gen_count never wraps within a run, since num_gens fits in GEN_W.
- grid_out and gen_count hold their values in IDLE and DONE.

Optional Feature:
- Macro: LIFE_STABLE_STOP_EN.
- When defined:
  - In RUN, if the computed next generation equals grid_out, the engine writes it, increments gen_count, sets stable=1 and goes to DONE, even if fewer than num_gens generations have run.
  - An extinct grid is a special case and stops immediately.
- When undefined:
  - The run always executes exactly num_gens generations.
  - stable is still reported but never alters control flow.

Decomposition:
- Package life_pkg:
  - state enum life_state_t {IDLE, RUN, DONE}.
  - Rule constants BIRTH_COUNT=3 and SURVIVE_COUNT=2.
  - Neighbour-count width constant NCOUNT_W=4.
- Sub-module life_cell_rule:
  - Combinational; 8 neighbour bits plus current state in, next state out.
  - Instantiated ROWS*COLS times through a generate loop.
  - Edge/wrap neighbour selection is done in life_engine.

Test Plan:
- 8x8, wrap=0, blinker:
  - load 0x1C000000, start num_gens=1: grid_out=0x0000000808080000, gen_count=1, done pulses 2 cycles after the start edge.
  - A further run with num_gens=1 returns 0x1C000000.
- 8x8, wrap=1, glider:
  - load 0x70402, num_gens=4: grid_out=0x0E080400.
  - Reload 0x70402, num_gens=32: grid_out=0x70402, gen_count=32.
- num_gens=0 with grid 0x1C000000: no RUN cycle, done pulses the cycle after start, grid unchanged, gen_count=0.
- Single cell 0x1, num_gens=5, wrap=0:
  - extinct=1 after generation 1.
  - With LIFE_STABLE_STOP_EN: done at gen_count=1, stable=1.
  - Without the macro: gen_count=5.
- Abort and simultaneous events:
  - Blinker with num_gens=100, abort after 3 RUN cycles: IDLE, done never asserts, gen_count=3, grid_out=0x0000000808080000.
  - load_valid+start asserted together: load accepted, start ignored.
- Reset mid-run: reset=0 for one edge during RUN: all outputs return to their reset values the next cycle and load_ready=1.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game of Life engine.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } life_state_t;

    localparam int NCOUNT_W = 4;

    localparam logic [NCOUNT_W-1:0] BIRTH_COUNT   = NCOUNT_W'(3);
    localparam logic [NCOUNT_W-1:0] SURVIVE_COUNT = NCOUNT_W'(2);

endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for a single cell, given its eight neighbours and current state.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [7:0] neighbours_i,
    input  logic       alive_i,
    output logic       alive_o
);

    logic [NCOUNT_W-1:0] count;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + NCOUNT_W'(neighbours_i[i]);
        end
        alive_o = (count == BIRTH_COUNT) || (alive_i && (count == SURVIVE_COUNT));
    end

endmodule

// File: rtl/life_engine.sv
// Sequential Game of Life engine: load a grid, run N generations at one per clock.
// Define LIFE_STABLE_STOP_EN to end a run early once the grid stops changing.
module life_engine
    import life_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [ROWS*COLS-1:0] load_grid,
    input  logic                 start,
    input  logic [GEN_W-1:0]     num_gens,
    input  logic                 wrap,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 extinct,
    output logic                 stable
);

    localparam int CELLS = ROWS * COLS;

    life_state_t      state_q, state_d;
    logic [CELLS-1:0] grid_q, grid_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [GEN_W-1:0] num_q, num_d;
    logic             wrap_q, wrap_d;
    logic             stable_q, stable_d;

    logic [CELLS-1:0] next_grid;
    logic [GEN_W-1:0] gen_inc;
    logic             no_change;
    logic             stop_early;

    // Neighbour k walks the 3x3 window row-major; k==4 is the cell itself.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nbrs;
            for (genvar k = 0; k < 9; k++) begin : g_nb
                if (k != 4) begin : g_use
                    localparam int RR     = r + (k / 3) - 1;
                    localparam int CC     = c + (k % 3) - 1;
                    localparam int RW     = (RR + ROWS) % ROWS;
                    localparam int CW     = (CC + COLS) % COLS;
                    localparam int SLOT   = (k < 4) ? k : k - 1;
                    localparam bit INSIDE = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                    if (INSIDE) begin : g_in
                        assign nbrs[SLOT] = grid_q[RR*COLS + CC];
                    end else begin : g_edge
                        assign nbrs[SLOT] = wrap_q & grid_q[RW*COLS + CW];
                    end
                end
            end
            life_cell_rule u_rule (
                .neighbours_i (nbrs),
                .alive_i      (grid_q[r*COLS + c]),
                .alive_o      (next_grid[r*COLS + c])
            );
        end
    end

    assign gen_inc   = gen_q + GEN_W'(1);
    assign no_change = (next_grid == grid_q);
`ifdef LIFE_STABLE_STOP_EN
    assign stop_early = no_change || (next_grid == '0);
`else
    assign stop_early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) begin
            state_q  <= IDLE;
            grid_q   <= '0;
            gen_q    <= '0;
            num_q    <= '0;
            wrap_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            gen_q    <= gen_d;
            num_q    <= num_d;
            wrap_q   <= wrap_d;
            stable_q <= stable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grid_d   = grid_q;
        gen_d    = gen_q;
        num_d    = num_q;
        wrap_d   = wrap_q;
        stable_d = stable_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    grid_d   = load_grid;
                    stable_d = 1'b0;
                end else if (start) begin
                    num_d   = num_gens;
                    wrap_d  = wrap;
                    gen_d   = '0;
                    state_d = (num_gens == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort beats completion and freezes the grid and counter.
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    grid_d   = next_grid;
                    gen_d    = gen_inc;
                    stable_d = no_change || stop_early;
                    if ((gen_inc == num_q) || stop_early) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
    end

    assign grid_out  = grid_q;
    assign gen_count = gen_q;
    assign stable    = stable_q;
    assign extinct   = ~|grid_q;

endmodule
